umi_req_arb2: RTL and testbench

- Two-host front end placed directly upstream of umi_mem_agent.
- Request path: round-robin arbitration of two host UMI request streams into the single udev_req port, through a one-entry output register.
- Response path: combinational demux of udev_resp back to the originating host, selected by one dstaddr bit.
- Multi-beat transactions (EOM=0 beats) are never interleaved between hosts.

---
 rtl/umi_req_arb2.sv | 207 ++++++++++++++++++++
 tb/tb_umi_req_arb2.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/umi_req_arb2.sv
// ---------------------------------------------------------------------------
// umi_req_arb2
//
// Two-host front end that sits directly upstream of umi_mem_agent.
//
// Request path: two host UMI request streams are round-robin arbitrated into
// the single udev_req port through a one-entry output register. A host that
// issues a beat with EOM=0 keeps the grant until it issues its EOM=1 beat, so
// multi-beat transactions from the two hosts are never interleaved.
//
// Response path: udev_resp is demultiplexed combinationally back to the host
// selected by udev_resp_dstaddr[ROUTE_BIT] (0 -> host0, 1 -> host1). Payload
// fields are broadcast to both hosts; only valid is steered.
//
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   h0_req_* / h1_req_*          host request streams (valid/ready handshake)
//   udev_req_*                   registered arbitrated request to the device
//   udev_resp_*                  device response stream
//   h0_resp_* / h1_resp_*        demultiplexed response streams to the hosts
// ---------------------------------------------------------------------------
module umi_req_arb2 #(
  parameter int CW        = 32,
  parameter int AW        = 64,
  parameter int DW        = 256,
  parameter int ROUTE_BIT = 63,
  parameter int EOM_BIT   = 22
) (
  input  logic          clk,
  input  logic          reset,

  // host0 request
  input  logic          h0_req_valid,
  input  logic [CW-1:0] h0_req_cmd,
  input  logic [AW-1:0] h0_req_dstaddr,
  input  logic [AW-1:0] h0_req_srcaddr,
  input  logic [DW-1:0] h0_req_data,
  output logic          h0_req_ready,

  // host1 request
  input  logic          h1_req_valid,
  input  logic [CW-1:0] h1_req_cmd,
  input  logic [AW-1:0] h1_req_dstaddr,
  input  logic [AW-1:0] h1_req_srcaddr,
  input  logic [DW-1:0] h1_req_data,
  output logic          h1_req_ready,

  // arbitrated request to the device
  output logic          udev_req_valid,
  output logic [CW-1:0] udev_req_cmd,
  output logic [AW-1:0] udev_req_dstaddr,
  output logic [AW-1:0] udev_req_srcaddr,
  output logic [DW-1:0] udev_req_data,
  input  logic          udev_req_ready,

  // device response
  input  logic          udev_resp_valid,
  input  logic [CW-1:0] udev_resp_cmd,
  input  logic [AW-1:0] udev_resp_dstaddr,
  input  logic [AW-1:0] udev_resp_srcaddr,
  input  logic [DW-1:0] udev_resp_data,
  output logic          udev_resp_ready,

  // host0 response
  output logic          h0_resp_valid,
  output logic [CW-1:0] h0_resp_cmd,
  output logic [AW-1:0] h0_resp_dstaddr,
  output logic [AW-1:0] h0_resp_srcaddr,
  output logic [DW-1:0] h0_resp_data,
  input  logic          h0_resp_ready,

  // host1 response
  output logic          h1_resp_valid,
  output logic [CW-1:0] h1_resp_cmd,
  output logic [AW-1:0] h1_resp_dstaddr,
  output logic [AW-1:0] h1_resp_srcaddr,
  output logic [DW-1:0] h1_resp_data,
  input  logic          h1_resp_ready
);

  // Output register stage and arbitration state
  logic          r_vld_p1;
  logic [CW-1:0] r_cmd_p1;
  logic [AW-1:0] r_dstaddr_p1;
  logic [AW-1:0] r_srcaddr_p1;
  logic [DW-1:0] r_data_p1;
  logic          r_last_host;   // host that won the most recent accepted beat
  logic          r_lock;        // a multi-beat transaction is in progress
  logic          r_lock_host;   // owner of the in-progress transaction

  // Arbitration and selection
  logic          w_slot_free;
  logic          w_gnt_vld;
  logic          w_gnt_host;
  logic          w_sel_valid;
  logic [CW-1:0] w_sel_cmd;
  logic [AW-1:0] w_sel_dstaddr;
  logic [AW-1:0] w_sel_srcaddr;
  logic [DW-1:0] w_sel_data;
  logic          w_accept;

  // Response routing
  logic          w_resp_sel;

  // -------------------------------------------------------------------------
  // Stage p0: grant selection (combinational, no dependence on ready for
  // anything that feeds a valid output)
  // -------------------------------------------------------------------------

  // The slot can take a new beat when it is empty or draining this cycle.
  assign w_slot_free = ~r_vld_p1 | udev_req_ready;

  // A held lock overrides arbitration even while the locked host is idle, so
  // the other host cannot slip a beat into the middle of a transaction.
  always_comb begin
    w_gnt_vld  = 1'b0;
    w_gnt_host = 1'b0;
    if (r_lock) begin
      w_gnt_vld  = 1'b1;
      w_gnt_host = r_lock_host;
    end else if (h0_req_valid && h1_req_valid) begin
      w_gnt_vld  = 1'b1;
      w_gnt_host = ~r_last_host;
    end else if (h0_req_valid) begin
      w_gnt_vld  = 1'b1;
      w_gnt_host = 1'b0;
    end else if (h1_req_valid) begin
      w_gnt_vld  = 1'b1;
      w_gnt_host = 1'b1;
    end
  end

  always_comb begin
    if (w_gnt_host) begin
      w_sel_valid   = h1_req_valid;
      w_sel_cmd     = h1_req_cmd;
      w_sel_dstaddr = h1_req_dstaddr;
      w_sel_srcaddr = h1_req_srcaddr;
      w_sel_data    = h1_req_data;
    end else begin
      w_sel_valid   = h0_req_valid;
      w_sel_cmd     = h0_req_cmd;
      w_sel_dstaddr = h0_req_dstaddr;
      w_sel_srcaddr = h0_req_srcaddr;
      w_sel_data    = h0_req_data;
    end
  end

  assign w_accept = w_gnt_vld & w_sel_valid & w_slot_free;

  assign h0_req_ready = w_gnt_vld & ~w_gnt_host & w_slot_free;
  assign h1_req_ready = w_gnt_vld &  w_gnt_host & w_slot_free;

  // -------------------------------------------------------------------------
  // Stage p1: output register, pointer and lock update
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld_p1     <= 1'b0;
      r_last_host  <= 1'b1;   // host0 wins the first tie after reset
      r_lock       <= 1'b0;
      r_lock_host  <= 1'b0;
      r_cmd_p1     <= '0;
      r_dstaddr_p1 <= '0;
      r_srcaddr_p1 <= '0;
      r_data_p1    <= '0;
    end else if (w_accept) begin
      r_vld_p1     <= 1'b1;
      r_cmd_p1     <= w_sel_cmd;
      r_dstaddr_p1 <= w_sel_dstaddr;
      r_srcaddr_p1 <= w_sel_srcaddr;
      r_data_p1    <= w_sel_data;
      r_last_host  <= w_gnt_host;
      // EOM=0 opens (or continues) a transaction; EOM=1 closes it.
      r_lock       <= ~w_sel_cmd[EOM_BIT];
      r_lock_host  <= w_gnt_host;
    end else if (udev_req_ready) begin
      r_vld_p1     <= 1'b0;
    end
  end

  assign udev_req_valid   = r_vld_p1;
  assign udev_req_cmd     = r_cmd_p1;
  assign udev_req_dstaddr = r_dstaddr_p1;
  assign udev_req_srcaddr = r_srcaddr_p1;
  assign udev_req_data    = r_data_p1;

  // -------------------------------------------------------------------------
  // Response demux (stateless, zero latency)
  // -------------------------------------------------------------------------
  assign w_resp_sel = udev_resp_dstaddr[ROUTE_BIT];

  assign h0_resp_valid   = udev_resp_valid & ~w_resp_sel;
  assign h1_resp_valid   = udev_resp_valid &  w_resp_sel;
  assign udev_resp_ready = w_resp_sel ? h1_resp_ready : h0_resp_ready;

  assign h0_resp_cmd     = udev_resp_cmd;
  assign h0_resp_dstaddr = udev_resp_dstaddr;
  assign h0_resp_srcaddr = udev_resp_srcaddr;
  assign h0_resp_data    = udev_resp_data;

  assign h1_resp_cmd     = udev_resp_cmd;
  assign h1_resp_dstaddr = udev_resp_dstaddr;
  assign h1_resp_srcaddr = udev_resp_srcaddr;
  assign h1_resp_data    = udev_resp_data;

endmodule

// File: tb/tb_umi_req_arb2.sv
module tb_umi_req_arb2;
  localparam int CW        = 32;
  localparam int AW        = 64;
  localparam int DW        = 256;
  localparam int ROUTE_BIT = 63;
  localparam int EOM_BIT   = 22;

  logic          clk = 1'b0;
  logic          reset;
  logic          h0_req_valid, h1_req_valid;
  logic [CW-1:0] h0_req_cmd, h1_req_cmd;
  logic [AW-1:0] h0_req_dstaddr, h1_req_dstaddr, h0_req_srcaddr, h1_req_srcaddr;
  logic [DW-1:0] h0_req_data, h1_req_data;
  logic          h0_req_ready, h1_req_ready;
  logic          udev_req_valid, udev_req_ready;
  logic [CW-1:0] udev_req_cmd;
  logic [AW-1:0] udev_req_dstaddr, udev_req_srcaddr;
  logic [DW-1:0] udev_req_data;
  logic          udev_resp_valid, udev_resp_ready;
  logic [CW-1:0] udev_resp_cmd;
  logic [AW-1:0] udev_resp_dstaddr, udev_resp_srcaddr;
  logic [DW-1:0] udev_resp_data;
  logic          h0_resp_valid, h1_resp_valid, h0_resp_ready, h1_resp_ready;
  logic [CW-1:0] h0_resp_cmd, h1_resp_cmd;
  logic [AW-1:0] h0_resp_dstaddr, h1_resp_dstaddr, h0_resp_srcaddr, h1_resp_srcaddr;
  logic [DW-1:0] h0_resp_data, h1_resp_data;

  always #5 clk = ~clk;

  umi_req_arb2 #(.CW(CW), .AW(AW), .DW(DW), .ROUTE_BIT(ROUTE_BIT), .EOM_BIT(EOM_BIT)) dut (
    .clk(clk), .reset(reset),
    .h0_req_valid(h0_req_valid), .h0_req_cmd(h0_req_cmd), .h0_req_dstaddr(h0_req_dstaddr),
    .h0_req_srcaddr(h0_req_srcaddr), .h0_req_data(h0_req_data), .h0_req_ready(h0_req_ready),
    .h1_req_valid(h1_req_valid), .h1_req_cmd(h1_req_cmd), .h1_req_dstaddr(h1_req_dstaddr),
    .h1_req_srcaddr(h1_req_srcaddr), .h1_req_data(h1_req_data), .h1_req_ready(h1_req_ready),
    .udev_req_valid(udev_req_valid), .udev_req_cmd(udev_req_cmd), .udev_req_dstaddr(udev_req_dstaddr),
    .udev_req_srcaddr(udev_req_srcaddr), .udev_req_data(udev_req_data), .udev_req_ready(udev_req_ready),
    .udev_resp_valid(udev_resp_valid), .udev_resp_cmd(udev_resp_cmd), .udev_resp_dstaddr(udev_resp_dstaddr),
    .udev_resp_srcaddr(udev_resp_srcaddr), .udev_resp_data(udev_resp_data), .udev_resp_ready(udev_resp_ready),
    .h0_resp_valid(h0_resp_valid), .h0_resp_cmd(h0_resp_cmd), .h0_resp_dstaddr(h0_resp_dstaddr),
    .h0_resp_srcaddr(h0_resp_srcaddr), .h0_resp_data(h0_resp_data), .h0_resp_ready(h0_resp_ready),
    .h1_resp_valid(h1_resp_valid), .h1_resp_cmd(h1_resp_cmd), .h1_resp_dstaddr(h1_resp_dstaddr),
    .h1_resp_srcaddr(h1_resp_srcaddr), .h1_resp_data(h1_resp_data), .h1_resp_ready(h1_resp_ready)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: who owns an open transaction (-1 = nobody), who won
  // last, and what the device currently sees.
  int            m_owner = -1;
  int            m_last  = 1;
  bit            m_valid = 1'b0;
  logic [CW-1:0] m_cmd   = '0;
  logic [AW-1:0] m_dst   = '0;
  logic [AW-1:0] m_src   = '0;
  logic [DW-1:0] m_data  = '0;

  function automatic int exp_grant();
    if (m_owner >= 0) return m_owner;
    if (h0_req_valid && h1_req_valid) return 1 - m_last;
    if (h0_req_valid) return 0;
    if (h1_req_valid) return 1;
    return -1;
  endfunction

  function automatic bit exp_ready(input int h);
    return (exp_grant() == h) && (!m_valid || udev_req_ready);
  endfunction

  // Advance one clock and update the model with what the rules say happened.
  task automatic tick();
    int g;
    bit acc;
    g   = exp_grant();
    acc = ((g == 0 && h0_req_valid) || (g == 1 && h1_req_valid)) && (!m_valid || udev_req_ready);
    @(posedge clk);
    if (reset) begin
      m_valid = 0; m_owner = -1; m_last = 1;
      m_cmd = '0; m_dst = '0; m_src = '0; m_data = '0;
    end else if (acc) begin
      m_valid = 1; m_last = g;
      if (g == 0) begin
        m_cmd = h0_req_cmd; m_dst = h0_req_dstaddr; m_src = h0_req_srcaddr; m_data = h0_req_data;
      end else begin
        m_cmd = h1_req_cmd; m_dst = h1_req_dstaddr; m_src = h1_req_srcaddr; m_data = h1_req_data;
      end
      m_owner = m_cmd[EOM_BIT] ? -1 : g;
    end else if (udev_req_ready) begin
      m_valid = 0;
    end
    #1;
  endtask

  task automatic drive_h0(input bit v, input bit eom, input logic [DW-1:0] d);
    h0_req_valid = v; h0_req_cmd = $urandom; h0_req_cmd[EOM_BIT] = eom;
    h0_req_dstaddr = {$urandom, $urandom}; h0_req_srcaddr = {$urandom, $urandom}; h0_req_data = d;
  endtask

  task automatic drive_h1(input bit v, input bit eom, input logic [DW-1:0] d);
    h1_req_valid = v; h1_req_cmd = $urandom; h1_req_cmd[EOM_BIT] = eom;
    h1_req_dstaddr = {$urandom, $urandom}; h1_req_srcaddr = {$urandom, $urandom}; h1_req_data = d;
  endtask

  task automatic idle();
    drive_h0(0, 1, '0); drive_h1(0, 1, '0); udev_req_ready = 1; reset = 0;
    tick(); tick();
  endtask

  task automatic do_reset();
    drive_h0(0, 1, '0); drive_h1(0, 1, '0); udev_req_ready = 1;
    reset = 1; tick(); reset = 0;
  endtask

  task automatic test_reset();
    drive_h0(1, 1, 256'hDEAD); drive_h1(0, 1, '0); udev_req_ready = 1;
    reset = 1; tick(); tick();
    drive_h0(0, 1, '0);
    @(negedge clk);
    vectors++;
    if (udev_req_valid !== 1'b0 || udev_req_cmd !== '0 || udev_req_data !== '0 || udev_req_dstaddr !== '0) begin
      miscompares++;
      $display("FAIL reset_state: valid=%b cmd=%h data=%h required valid=0 payload=0", udev_req_valid, udev_req_cmd, udev_req_data);
    end
    vectors++;
    if (h0_req_ready !== 1'b0 || h1_req_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle_ready: h0=%b h1=%b required 0/0", h0_req_ready, h1_req_ready);
    end
    drive_h0(1, 1, '0); drive_h1(1, 1, '0);
    #1;
    vectors++;
    if (h0_req_ready !== 1'b1 || h1_req_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_first_tie: h0=%b h1=%b required 1/0", h0_req_ready, h1_req_ready);
    end
    reset = 0;
    idle();
  endtask

  task automatic test_single_stream();
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) drive_h0(1, 1, DW'(i)); else drive_h0(0, 1, '0);
      drive_h1(0, 1, '0);
      @(negedge clk);
      vectors++;
      if (h1_req_ready !== 1'b0) begin
        miscompares++; $display("FAIL single_h1_ready cycle %0d: got %b required 0", i, h1_req_ready);
      end
      if (i <= 4) begin
        vectors++;
        if (h0_req_ready !== 1'b1) begin
          miscompares++; $display("FAIL single_h0_ready cycle %0d: got %b required 1", i, h0_req_ready);
        end
      end
      if (i >= 2) begin
        vectors++;
        if (udev_req_valid !== 1'b1 || udev_req_data !== DW'(i - 1)) begin
          miscompares++;
          $display("FAIL single_data cycle %0d: valid=%b data=%0h required valid=1 data=%0h", i, udev_req_valid, udev_req_data, i - 1);
        end
      end
      tick();
    end
    @(negedge clk);
    vectors++;
    if (udev_req_valid !== 1'b0) begin
      miscompares++; $display("FAIL single_drain: valid=%b required 0", udev_req_valid);
    end
    idle();
  endtask

  task automatic test_round_robin();
    int exp_host;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      exp_host = i % 2;
      drive_h0(i < 8, 1, DW'(32'h100 + i));
      drive_h1(i < 8, 1, DW'(32'h200 + i));
      @(negedge clk);
      if (i < 8) begin
        vectors++;
        if (h0_req_ready !== (exp_host == 0) || h1_req_ready !== (exp_host == 1)) begin
          miscompares++;
          $display("FAIL rr_grant cycle %0d: h0=%b h1=%b required host %0d", i, h0_req_ready, h1_req_ready, exp_host);
        end
      end
      if (i >= 1) begin
        vectors++;
        if (udev_req_valid !== 1'b1 ||
            udev_req_data !== DW'(((i - 1) % 2 == 0) ? (32'h100 + i - 1) : (32'h200 + i - 1))) begin
          miscompares++;
          $display("FAIL rr_data cycle %0d: valid=%b data=%0h", i, udev_req_valid, udev_req_data);
        end
      end
      tick();
    end
    idle();
  endtask

  task automatic test_lock();
    do_reset();
    for (int i = 0; i <= 4; i++) begin
      drive_h0(i < 3, (i == 2), DW'(32'hA0 + i));
      drive_h1(1, 1, DW'(32'hB0 + i));
      @(negedge clk);
      vectors++;
      if (i < 3) begin
        if (h0_req_ready !== 1'b1 || h1_req_ready !== 1'b0) begin
          miscompares++;
          $display("FAIL lock_burst cycle %0d: h0=%b h1=%b required 1/0", i, h0_req_ready, h1_req_ready);
        end
      end else if (h1_req_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL lock_release cycle %0d: h1=%b required 1", i, h1_req_ready);
      end
      if (i >= 1) begin
        vectors++;
        if (udev_req_valid !== 1'b1 || udev_req_data !== DW'((i <= 3) ? (32'hA0 + i - 1) : 32'hB3)) begin
          miscompares++;
          $display("FAIL lock_data cycle %0d: valid=%b data=%0h", i, udev_req_valid, udev_req_data);
        end
      end
      tick();
    end
    idle();
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i <= 7; i++) begin
      udev_req_ready = (i == 0 || i >= 6);
      drive_h0(1, 1, DW'(32'h50 + i));
      drive_h1(0, 1, '0);
      @(negedge clk);
      if (i >= 1 && i <= 5) begin
        vectors++;
        if (h0_req_ready !== 1'b0 || udev_req_valid !== 1'b1 || udev_req_data !== DW'(32'h50)) begin
          miscompares++;
          $display("FAIL bp_hold cycle %0d: h0_ready=%b valid=%b data=%0h required 0/1/50", i, h0_req_ready, udev_req_valid, udev_req_data);
        end
      end
      if (i == 6) begin
        vectors++;
        if (h0_req_ready !== 1'b1 || udev_req_data !== DW'(32'h50)) begin
          miscompares++;
          $display("FAIL bp_release: h0_ready=%b data=%0h required 1/50", h0_req_ready, udev_req_data);
        end
      end
      if (i == 7) begin
        vectors++;
        if (udev_req_valid !== 1'b1 || udev_req_data !== DW'(32'h56)) begin
          miscompares++;
          $display("FAIL bp_no_bubble: valid=%b data=%0h required 1/56", udev_req_valid, udev_req_data);
        end
      end
      tick();
    end
    idle();
  endtask

  task automatic test_resp_routing();
    udev_resp_valid = 1; udev_resp_cmd = 32'h1234_5678;
    udev_resp_dstaddr = 64'h8000_0000_0000_00F0; udev_resp_srcaddr = 64'h55;
    udev_resp_data = DW'(32'hCAFE);
    h0_resp_ready = 1; h1_resp_ready = 0;
    @(negedge clk);
    vectors++;
    if (h1_resp_valid !== 1'b1 || h0_resp_valid !== 1'b0 || udev_resp_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL resp_h1_stall: h0v=%b h1v=%b rdy=%b required 0/1/0", h0_resp_valid, h1_resp_valid, udev_resp_ready);
    end
    h1_resp_ready = 1;
    #1;
    vectors++;
    if (udev_resp_ready !== 1'b1 || h1_resp_data !== DW'(32'hCAFE) || h0_resp_cmd !== 32'h1234_5678) begin
      miscompares++;
      $display("FAIL resp_h1_go: rdy=%b data=%0h cmd=%h required 1/cafe/12345678", udev_resp_ready, h1_resp_data, h0_resp_cmd);
    end
    udev_resp_dstaddr = 64'h0000_0000_0000_00F0; h0_resp_ready = 0;
    #1;
    vectors++;
    if (h0_resp_valid !== 1'b1 || h1_resp_valid !== 1'b0 || udev_resp_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL resp_h0_stall: h0v=%b h1v=%b rdy=%b required 1/0/0", h0_resp_valid, h1_resp_valid, udev_resp_ready);
    end
    h0_resp_ready = 1;
    #1;
    vectors++;
    if (udev_resp_ready !== 1'b1) begin
      miscompares++; $display("FAIL resp_h0_go: rdy=%b required 1", udev_resp_ready);
    end
    udev_resp_valid = 0;
    #1;
    vectors++;
    if (h0_resp_valid !== 1'b0 || h1_resp_valid !== 1'b0) begin
      miscompares++; $display("FAIL resp_idle: h0v=%b h1v=%b required 0/0", h0_resp_valid, h1_resp_valid);
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    drive_h0(0, 1, '0); drive_h1(1, 0, DW'(32'h77));
    tick();
    drive_h1(0, 1, '0); reset = 1;
    tick();
    reset = 0;
    @(negedge clk);
    vectors++;
    if (udev_req_valid !== 1'b0) begin
      miscompares++; $display("FAIL midrst_valid: got %b required 0", udev_req_valid);
    end
    drive_h0(1, 1, '0); drive_h1(1, 1, '0);
    #1;
    vectors++;
    if (h0_req_ready !== 1'b1 || h1_req_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_tie: h0=%b h1=%b required 1/0 (lock cleared, host0 first)", h0_req_ready, h1_req_ready);
    end
    tick();
    idle();
  endtask

  task automatic test_random();
    logic [DW-1:0] d;
    bit            sel;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < 8; k++) d[k*32 +: 32] = $urandom;
      drive_h0($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, d);
      for (int k = 0; k < 8; k++) d[k*32 +: 32] = $urandom;
      drive_h1($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, d);
      udev_req_ready = $urandom_range(0, 9) < 7;
      reset = ($urandom_range(0, 49) == 0);
      udev_resp_valid = $urandom; udev_resp_cmd = $urandom;
      udev_resp_dstaddr = {$urandom, $urandom}; udev_resp_srcaddr = {$urandom, $urandom};
      udev_resp_data = d;
      h0_resp_ready = $urandom; h1_resp_ready = $urandom;
      @(negedge clk);
      vectors++;
      if (h0_req_ready !== exp_ready(0) || h1_req_ready !== exp_ready(1)) begin
        miscompares++;
        $display("FAIL rand_ready n=%0d: h0=%b h1=%b required %b/%b", n, h0_req_ready, h1_req_ready, exp_ready(0), exp_ready(1));
      end
      vectors++;
      if (udev_req_valid !== m_valid ||
          (m_valid && (udev_req_cmd !== m_cmd || udev_req_dstaddr !== m_dst ||
                       udev_req_srcaddr !== m_src || udev_req_data !== m_data))) begin
        miscompares++;
        $display("FAIL rand_out n=%0d: valid=%b cmd=%h required valid=%b cmd=%h", n, udev_req_valid, udev_req_cmd, m_valid, m_cmd);
      end
      sel = udev_resp_dstaddr[ROUTE_BIT];
      vectors++;
      if (h0_resp_valid !== (udev_resp_valid && !sel) || h1_resp_valid !== (udev_resp_valid && sel) ||
          udev_resp_ready !== (sel ? h1_resp_ready : h0_resp_ready) ||
          h0_resp_data !== udev_resp_data || h1_resp_srcaddr !== udev_resp_srcaddr) begin
        miscompares++;
        $display("FAIL rand_resp n=%0d: h0v=%b h1v=%b rdy=%b sel=%b", n, h0_resp_valid, h1_resp_valid, udev_resp_ready, sel);
      end
      tick();
    end
    reset = 0;
    idle();
  endtask

  initial begin
    reset = 1; udev_req_ready = 1;
    drive_h0(0, 1, '0); drive_h1(0, 1, '0);
    udev_resp_valid = 0; udev_resp_cmd = '0; udev_resp_dstaddr = '0;
    udev_resp_srcaddr = '0; udev_resp_data = '0;
    h0_resp_ready = 0; h1_resp_ready = 0;
    #1;
    test_reset();
    test_single_stream();
    test_round_robin();
    test_lock();
    test_backpressure();
    test_resp_routing();
    test_reset_mid_burst();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
